// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader: fills instruction store, then releases the CPU.
// Optional checksum byte after the last word when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
   parameter int DEPTH  = 14,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_start,
   output logic [7:0]        start_pc,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE, GET_PC, GET_BYTE, WRITE, START, ERROR, GET_CSUM
   } state_t;

   state_t            state, nxt;
   logic [7:0]        cnt_n;
   logic [7:0]        pc_q;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_idx;
   logic [31:0]       asm_word;
   logic              ready_en;
   logic              acc;
   logic              take;
   logic              last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   // ready_en keeps in_ready low through reset and up to the first edge after release
   assign acc       = in_valid && ready_en;
   assign take      = in_valid && in_ready;
   assign last_word = (8'(word_idx) == cnt_n - 8'd1);

   assign imem_addr  = word_idx;
   assign imem_wdata = asm_word;
   assign start_pc   = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      imem_we   = 1'b0;
      cpu_start = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ready_en;
            busy     = 1'b0;
            if (acc) nxt = (in_data == 8'd0 || in_data > 8'(DEPTH)) ? ERROR : GET_PC;
         end
         GET_PC: begin
            in_ready = ready_en;
            if (acc) nxt = (in_data >= cnt_n) ? ERROR : GET_BYTE;
         end
         GET_BYTE: begin
            in_ready = ready_en;
            if (acc && byte_idx == 2'd3) nxt = WRITE;
         end
         WRITE: begin
            imem_we = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            nxt = last_word ? GET_CSUM : GET_BYTE;
`else
            nxt = last_word ? START : GET_BYTE;
`endif
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         GET_CSUM: begin
            in_ready = ready_en;
            if (acc) nxt = (in_data == csum) ? START : ERROR;
         end
`endif
         START: begin
            cpu_start = 1'b1;
            nxt       = IDLE;
         end
         ERROR: begin
            err  = 1'b1;
            busy = 1'b0;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         cnt_n    <= 8'd0;
         pc_q     <= 8'd0;
         word_idx <= '0;
         byte_idx <= 2'd0;
         asm_word <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum     <= 8'd0;
`endif
      end else begin
         ready_en <= 1'b1;
         if (take) begin
            case (state)
               IDLE: cnt_n <= in_data;
               GET_PC: begin
                  pc_q     <= in_data;
                  word_idx <= '0;
                  byte_idx <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum     <= 8'd0;
`endif
               end
               GET_BYTE: begin
                  asm_word <= {asm_word[23:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
               end
               default: ;
            endcase
         end
         if (state == WRITE && !last_word) word_idx <= word_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader.
module tb_prog_loader;
   localparam int DEPTH  = 14;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_start;
   logic [7:0]        start_pc;
   logic              busy;
   logic              err;

   int          tests = 0;
   int          fails = 0;
   int          starts = 0;
   logic [7:0]  last_pc = 8'h00;
   logic [35:0] exp_q[$];
   logic [31:0] wbuf[16];

   prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_start(cpu_start), .start_pc(start_pc),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // scoreboard: every write must match the oldest expected (addr, word)
   always @(negedge clk) begin
      logic [35:0] e;
      if (imem_we) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== e) begin
               fails++;
               $display("FAIL write_data: got %0d:%h required %0d:%h", imem_addr, imem_wdata, e[35:32], e[31:0]);
            end
         end
      end
      if (cpu_start === 1'b1) begin
         starts++;
         last_pc = start_pc;
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int t;
      idle_cycles(stall);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL byte_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int idx, input int stall, input bit expect_write);
      if (expect_write) exp_q.push_back({4'(idx), w});
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], stall);
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (imem_we !== 1'b1 || imem_addr !== 4'(idx)) begin
         fails++;
         $display("FAIL write_latency: we=%b addr=%0d required we=1 addr=%0d", imem_we, imem_addr, idx);
      end
   endtask

   task automatic load(input logic [7:0] n, input logic [7:0] pc, input int stall, input logic [7:0] csum_flip);
      logic [7:0] cs;
      cs = 8'h00;
      send_byte(n, stall);
      send_byte(pc, stall);
      for (int w = 0; w < int'(n); w++) begin
         cs = cs ^ wbuf[w][31:24] ^ wbuf[w][23:16] ^ wbuf[w][15:8] ^ wbuf[w][7:0];
         send_word(wbuf[w], w, stall, 1'b1);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(cs ^ csum_flip, stall);
`else
      cs = cs ^ csum_flip;
`endif
      idle_cycles(4);
   endtask

   task automatic check_done(input string name, input int s0, input int s_add, input logic [7:0] pc, input logic e);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_writes: %0d writes missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
      tests++;
      if (starts - s0 != s_add) begin
         fails++;
         $display("FAIL %s_starts: got %0d required %0d", name, starts - s0, s_add);
      end
      tests++;
      if (s_add > 0 && (last_pc !== pc || start_pc !== pc)) begin
         fails++;
         $display("FAIL %s_pc: got %h/%h required %h", name, last_pc, start_pc, pc);
      end
      tests++;
      if (err !== e) begin
         fails++;
         $display("FAIL %s_err: got %b required %b", name, err, e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, imem_we, cpu_start, busy, err} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 00000", {in_ready, imem_we, cpu_start, busy, err});
      end
      tests++;
      if (imem_addr !== 4'd0 || imem_wdata !== 32'd0 || start_pc !== 8'd0) begin
         fails++;
         $display("FAIL reset_data: got %h %h %h required 0 0 0", imem_addr, imem_wdata, start_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_before_edge: got %b required 0", in_ready);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_edge: got %b required 1", in_ready);
      end
   endtask

   task automatic test_continuous();
      int s0;
      s0 = starts;
      wbuf[0] = 32'h24020005;
      wbuf[1] = 32'h00000008;
      load(8'h02, 8'h00, 0, 8'h00);
      check_done("continuous", s0, 1, 8'h00, 1'b0);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL continuous_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_stalled();
      int s0;
      s0 = starts;
      load(8'h02, 8'h00, 3, 8'h00);
      check_done("stalled", s0, 1, 8'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      int s0;
      s0 = starts;
      for (int w = 0; w < DEPTH; w++) wbuf[w] = $urandom;
      load(8'(DEPTH), 8'(DEPTH - 1), 0, 8'h00);
      check_done("full_depth", s0, 1, 8'(DEPTH - 1), 1'b0);
   endtask

   task automatic test_bad_count();
      int s0;
      s0 = starts;
      send_byte(8'h0F, 0);
      @(negedge clk);
      tests++;
      if (err !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bad_count: err=%b in_ready=%b required 1/0", err, in_ready);
      end
      in_data = 8'h03;
      idle_cycles(0);
      for (int i = 0; i < 6; i++) @(negedge clk);
      in_valid = 1'b0;
      check_done("bad_count", s0, 0, 8'h00, 1'b1);
      do_reset();
      s0 = starts;
      send_byte(8'h00, 0);
      idle_cycles(2);
      check_done("zero_count", s0, 0, 8'h00, 1'b1);
      do_reset();
   endtask

   task automatic test_bad_pc();
      int s0;
      s0 = starts;
      send_byte(8'h03, 0);
      send_byte(8'h03, 0);
      idle_cycles(4);
      check_done("bad_pc", s0, 0, 8'h00, 1'b1);
      do_reset();
   endtask

   task automatic test_reset_mid_load();
      int s0;
      s0 = starts;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_word(32'hCAFEF00D, 0, 0, 1'b1);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, busy, imem_we, cpu_start} !== 4'b0) begin
         fails++;
         $display("FAIL midload_reset: got %b required 0000", {in_ready, busy, imem_we, cpu_start});
      end
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(4);
      check_done("midload", s0, 0, 8'h00, 1'b0);
      s0 = starts;
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'h9ABCDEF0;
      load(8'h02, 8'h01, 1, 8'h00);
      check_done("reload", s0, 1, 8'h01, 1'b0);
   endtask

`ifdef PROG_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int s0;
      s0 = starts;
      wbuf[0] = 32'h11223344;
      load(8'h01, 8'h00, 0, 8'h00);
      check_done("csum_ok", s0, 1, 8'h00, 1'b0);
      s0 = starts;
      load(8'h01, 8'h00, 0, 8'h01);
      check_done("csum_bad", s0, 0, 8'h00, 1'b1);
      do_reset();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_continuous();
      test_stalled();
      test_back_to_back();
      test_bad_count();
      test_bad_pc();
      test_reset_mid_load();
`ifdef PROG_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 14, instruction-store depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 4, instruction-store address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  byte-stream valid.
REQ-006 Port in_data  input  8  byte-stream data.
REQ-007 Port in_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port imem_we  output  1  instruction-store write strobe.
REQ-009 Port imem_addr  output  ADDR_W  instruction-store write address.
REQ-010 Port imem_wdata  output  32  instruction word.
REQ-011 Port cpu_start  output  1  one-cycle pulse releasing the processor.
REQ-012 Port start_pc  output  8  initial PC for the processor, valid while cpu_start=1 and held afterwards.
REQ-013 Port busy  output  1  a load is in progress.
REQ-014 Port err  output  1  sticky load error.

Function
REQ-015 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-016 Stream format SHALL be: count byte N, start-PC byte P, then N words of 4 bytes each, MSB first.
REQ-017 States SHALL be IDLE, GET_PC, GET_BYTE, WRITE, START and ERROR.
REQ-018 IDLE: in_ready=1, busy=0; accepted byte becomes N; N=0 or N>DEPTH -> ERROR, else -> GET_PC.
REQ-019 GET_PC: in_ready=1, busy=1; accepted byte becomes P; P>=N -> ERROR, else -> GET_BYTE with word index 0 and byte index 0.
REQ-020 GET_BYTE: in_ready=1; bytes shift into a 32-bit assembly register (first byte -> bits 31:24); after the 4th byte -> WRITE.
REQ-021 WRITE: in_ready=0; imem_we=1 for exactly one cycle with imem_addr=word index and imem_wdata=assembled word; if word index=N-1 -> START, else increment index and -> GET_BYTE.
REQ-022 Latency from acceptance of a word's 4th byte to its imem_we pulse SHALL be exactly one cycle.
REQ-023 START: in_ready=0; cpu_start=1 for one cycle, start_pc=P; next state IDLE, so a later stream reloads the store.
REQ-024 ERROR: err=1, in_ready=0, imem_we=0, cpu_start never asserted; state held until reset.
REQ-025 imem_we SHALL be 0 in every state except WRITE; imem_addr SHALL never reach DEPTH or above.
REQ-026 Stalls (in_valid=0) SHALL be permitted between any two bytes with no loss or reordering.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and zero in_ready-gating state: imem_we=0, imem_addr=0, imem_wdata=0, cpu_start=0, start_pc=0, busy=0, err=0, counters and assembly register 0.
REQ-028 In-memory reset, in_ready SHALL read 0; in_ready=1 from the first edge after rst_n rises.
REQ-029 Reset mid-load SHALL abandon the load without a further write or cpu_start; words already written remain in the store.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN, when defined, SHALL add state GET_CSUM after the last WRITE: one byte accepted, compared with XOR of all 4N payload bytes; match -> START, mismatch -> ERROR.
REQ-031 Without PROG_LOADER_CHECKSUM_EN, no checksum byte is expected and the last WRITE goes directly to START.

Verification
REQ-032 Stream 02,00,24020005,00000008 continuous -> imem writes [0]=24020005, [1]=00000008 on consecutive word boundaries; one cpu_start, start_pc=00.
REQ-033 Same stream with in_valid low 3 cycles between every byte -> identical writes and start; no extra imem_we.
REQ-034 Count byte 0F (DEPTH=14) -> err=1 next cycle, in_ready=0, no imem_we, no cpu_start until reset.
REQ-035 Count 03, start-PC 03 -> ERROR, no writes.
REQ-036 rst_n pulsed low after 6 payload bytes of a 2-word load -> one write at [0] only, no cpu_start; a fresh full stream afterwards loads and starts normally.
REQ-037 With PROG_LOADER_CHECKSUM_EN: 01,00,11223344, checksum 44 -> cpu_start; checksum 45 -> err=1, no cpu_start.
